// File: rtl/program_loader_if.sv
// Byte-stream links of the boot loader: RX FIFO pop side and program-memory write side.
// RX_flag is the FIFO's valid and data_bus_out its show-ahead head byte; a byte moves on a cycle
// with RX_use=1, which is only raised while RX_flag=1. wr_ins is a one-cycle write strobe, issued
// only while wr_idle=1; the next strobe waits until the memory reports wr_idle=1 again.
interface program_loader_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH_PM = 8
);
  logic                     load_start;
  logic [DATA_WIDTH-1:0]    data_bus_out;
  logic                     RX_flag;
  logic                     RX_use;
  logic [DATA_WIDTH-1:0]    data_bus_wr;
  logic [ADDR_WIDTH_PM-1:0] addr_wr;
  logic                     wr_ins;
  logic                     wr_idle;

  modport master (
    input  load_start, data_bus_out, RX_flag, wr_idle,
    output RX_use, data_bus_wr, addr_wr, wr_ins
  );

  modport slave (
    output load_start, data_bus_out, RX_flag, wr_idle,
    input  RX_use, data_bus_wr, addr_wr, wr_ins
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: copies UART RX bytes into program memory from address 0 until a terminator opcode.
// Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int         DATA_WIDTH          = 8,
  parameter int         INSTRUCTION_WIDTH   = 32,
  parameter int         PROGRAM_MEMORY_SIZE = 64,
  parameter int         ADDR_WIDTH_PM       = $clog2(PROGRAM_MEMORY_SIZE * 4),
  parameter logic [6:0] TERMINATE_OPCODE    = 7'b0001011
) (
  input  logic                         clk,
  input  logic                         rst_n,
  program_loader_if.master             bus,
  output logic                         loading,
  output logic                         boot_done,
  output logic                         load_error,
  output logic [ADDR_WIDTH_PM-2:0]     instr_count,
  output logic [2:0]                   fsm_state,
  output logic [INSTRUCTION_WIDTH-1:0] asm_instr
);

  localparam int CW = ADDR_WIDTH_PM - 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(PROGRAM_MEMORY_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    WRITE     = 3'd2,
    WAIT_ACK  = 3'd3,
    CHECK     = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , CHKSUM  = 3'd7
`endif
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH_PM-1:0] addr_q;
  logic [ADDR_WIDTH_PM-1:0] addr_wr_q;
  logic [DATA_WIDTH-1:0]    byte_q;
  logic [INSTRUCTION_WIDTH-1:0] instr_q;
  logic [CW-1:0]            count_q;
  logic                     rx_use;
  logic                     wr_ins;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]    csum_q;
`endif

  always_comb begin
    state_d = state_q;
    rx_use  = 1'b0;
    wr_ins  = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: if (bus.load_start) state_d = WAIT_BYTE;
      WAIT_BYTE: begin
        // Pop only when the memory can take the byte straight away.
        if (bus.RX_flag && bus.wr_idle) begin
          rx_use  = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_ins  = 1'b1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.wr_idle) state_d = (addr_q[1:0] == 2'd3) ? CHECK : WAIT_BYTE;
      end
      CHECK: begin
        if (instr_q[6:0] == TERMINATE_OPCODE) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = CHKSUM;
`else
          state_d = DONE;
`endif
        end else if (count_q == LAST_COUNT) begin
          state_d = ERROR;
        end else begin
          state_d = WAIT_BYTE;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHKSUM: begin
        if (bus.RX_flag) begin
          rx_use  = 1'b1;
          state_d = (bus.data_bus_out == csum_q) ? DONE : ERROR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      addr_wr_q <= '0;
      byte_q    <= '0;
      instr_q   <= '0;
      count_q   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (bus.load_start) begin
            addr_q  <= '0;
            instr_q <= '0;
            count_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        WAIT_BYTE: begin
          if (rx_use) begin
            byte_q    <= bus.data_bus_out;
            addr_wr_q <= addr_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q    <= csum_q ^ bus.data_bus_out;
`endif
          end
        end
        WAIT_ACK: begin
          // Little-endian: byte lane follows the low address bits.
          if (bus.wr_idle) begin
            addr_q <= addr_q + 1'b1;
            instr_q[DATA_WIDTH*addr_q[1:0] +: DATA_WIDTH] <= byte_q;
          end
        end
        CHECK: count_q <= count_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.RX_use      = rx_use;
  assign bus.wr_ins      = wr_ins;
  assign bus.data_bus_wr = byte_q;
  assign bus.addr_wr     = addr_wr_q;

  assign loading     = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
  assign boot_done   = (state_q == DONE);
  assign load_error  = (state_q == ERROR);
  assign instr_count = count_q;
  assign fsm_state   = state_q;
  assign asm_instr   = instr_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: RX FIFO and memory models, write scoreboard, summary line.
// Builds with or without PROGRAM_LOADER_CHECKSUM_EN; the checksum scenarios follow the macro.
`timescale 1ns/1ps
module tb_program_loader;
  localparam int AW = 8;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          loading, boot_done, load_error;
  logic [AW-2:0] instr_count;
  logic [2:0]    fsm_state;
  logic [31:0]   asm_instr;

  program_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH_PM(AW)) bus ();

  program_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .loading     (loading),
    .boot_done   (boot_done),
    .load_error  (load_error),
    .instr_count (instr_count),
    .fsm_state   (fsm_state),
    .asm_instr   (asm_instr)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0]    rx_q[$];
  logic [AW+7:0] exp_q[$];
  logic [7:0]    mem [0:255];
  logic [7:0]    prog_xor;
  logic [AW-1:0] exp_addr;
  int  rx_pops  = 0;
  int  wr_count = 0;
  int  wr_hold  = 0;
  int  wr_busy  = 0;
  bit  gap_mode = 1'b0;
  int  gap_cnt  = 0;
  int  gap_idx  = 0;
  bit  pop_req  = 1'b0;
  int  gap_tbl [8] = '{0, 3, 7, 1, 5, 2, 6, 4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // ---------------- monitor / scoreboard (mid-cycle sampling) ----------------
  always @(negedge clk) begin
    pop_req = bus.RX_use;
    if (bus.RX_use) begin
      rx_pops++;
      chk("pop_needs_flag", {31'd0, bus.RX_flag}, 32'd1);
    end
    if (!bus.wr_idle) chk("quiet_while_busy", {30'd0, bus.RX_use, bus.wr_ins}, 32'd0);
    if (bus.wr_ins) begin
      wr_count++;
      mem[bus.addr_wr] = bus.data_bus_wr;
      wr_busy = (wr_hold > 0) ? wr_hold + 1 : 0;
      chk("write_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() != 0) chk("write_addr_data", {16'd0, bus.addr_wr, bus.data_bus_wr}, {16'd0, exp_q.pop_front()});
    end
  end

  // ---------------- RX FIFO and memory-ready drivers ----------------
  always @(posedge clk) begin
    #1;
    if (pop_req) begin
      if (rx_q.size() != 0) void'(rx_q.pop_front());
      pop_req = 1'b0;
      if (gap_mode) begin
        gap_cnt = gap_tbl[gap_idx];
        gap_idx = (gap_idx + 1) % 8;
      end
    end else if (gap_cnt > 0) begin
      gap_cnt--;
    end
    if (wr_busy > 0) wr_busy--;
    bus.wr_idle      = (wr_busy == 0);
    bus.RX_flag      = (rx_q.size() != 0) && (gap_cnt == 0);
    bus.data_bus_out = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic new_prog();
    exp_addr = '0;
    prog_xor = '0;
    rx_pops  = 0;
    wr_count = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_q.push_back(b);
    exp_q.push_back({exp_addr, b});
    exp_addr = exp_addr + 1'b1;
    prog_xor = prog_xor ^ b;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) push_byte(w[8*i +: 8]);
  endtask

  task automatic push_csum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    rx_q.push_back(prog_xor);
`endif
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    tick(1);
    bus.load_start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int bound);
    int n = 0;
    while (!(boot_done || load_error) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finished"}, {31'd0, boot_done | load_error}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_loading"},    {31'd0, loading},     32'd0);
    chk({tag, "_boot_done"},  {31'd0, boot_done},   32'd0);
    chk({tag, "_load_error"}, {31'd0, load_error},  32'd0);
    chk({tag, "_instr_cnt"},  {25'd0, instr_count}, 32'd0);
    chk({tag, "_rx_use"},     {31'd0, bus.RX_use},  32'd0);
    chk({tag, "_wr_ins"},     {31'd0, bus.wr_ins},  32'd0);
    chk({tag, "_addr_wr"},    {24'd0, bus.addr_wr}, 32'd0);
    chk({tag, "_data_wr"},    {24'd0, bus.data_bus_wr}, 32'd0);
    chk({tag, "_state"},      {29'd0, fsm_state},   32'd0);
    chk({tag, "_asm"},        asm_instr,            32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n            = 1'b0;
    bus.load_start   = 1'b0;
    bus.RX_flag      = 1'b0;
    bus.data_bus_out = 8'h00;
    bus.wr_idle      = 1'b1;
    tick(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(1);

    // Two instructions, the second one the terminator 0x0000000B.
    new_prog();
    push_word(32'h0000_0513);
    push_word(32'h0000_000B);
    push_csum();
    pulse_start();
    wait_end("basic", 300);
    chk("basic_boot_done",  {31'd0, boot_done},  32'd1);
    chk("basic_load_error", {31'd0, load_error}, 32'd0);
    chk("basic_loading",    {31'd0, loading},    32'd0);
    chk("basic_instr_cnt",  {25'd0, instr_count}, 32'd2);
    chk("basic_rx_pops",    rx_pops,  8 + CSUM_BYTES);
    chk("basic_writes",     wr_count, 32'd8);
    chk("basic_mem0",       {24'd0, mem[0]}, 32'h13);
    chk("basic_mem1",       {24'd0, mem[1]}, 32'h05);
    chk("basic_mem4",       {24'd0, mem[4]}, 32'h0B);
    chk("basic_asm",        asm_instr, 32'h0000_000B);
    chk("basic_sb_empty",   exp_q.size(), 32'd0);
    // After DONE a waiting RX byte stays in the FIFO.
    rx_q.push_back(8'hAA);
    tick(10);
    chk("done_no_pop",      rx_q.size(), 32'd1);
    chk("done_no_write",    wr_count, 32'd8);
    chk("done_stays",       {31'd0, boot_done}, 32'd1);
    rx_q.delete();
    tick(2);

    // 64 instructions without a terminator overflow the memory.
    new_prog();
    for (int i = 0; i < 256; i++) push_byte((i % 4 == 0) ? 8'h13 : 8'(i));
    pulse_start();
    chk("ovf_cleared_done", {31'd0, boot_done}, 32'd0);
    wait_end("ovf", 3000);
    chk("ovf_load_error",   {31'd0, load_error}, 32'd1);
    chk("ovf_boot_done",    {31'd0, boot_done},  32'd0);
    chk("ovf_loading",      {31'd0, loading},    32'd0);
    chk("ovf_instr_cnt",    {25'd0, instr_count}, 32'd64);
    chk("ovf_writes",       wr_count, 32'd256);
    chk("ovf_mem255",       {24'd0, mem[255]}, 32'hFF);
    chk("ovf_mem252",       {24'd0, mem[252]}, 32'h13);
    chk("ovf_sb_empty",     exp_q.size(), 32'd0);

    // Slow memory: wr_idle low for 10 cycles after each write.
    wr_hold = 10;
    new_prog();
    push_word(32'h00A5_8533);
    push_word(32'h0000_018B);
    push_csum();
    pulse_start();
    chk("slow_error_clear", {31'd0, load_error}, 32'd0);
    wait_end("slow", 600);
    wr_hold = 0;
    chk("slow_boot_done",   {31'd0, boot_done}, 32'd1);
    chk("slow_instr_cnt",   {25'd0, instr_count}, 32'd2);
    chk("slow_writes",      wr_count, 32'd8);
    chk("slow_mem1",        {24'd0, mem[1]}, 32'h85);
    chk("slow_mem4",        {24'd0, mem[4]}, 32'h8B);
    chk("slow_sb_empty",    exp_q.size(), 32'd0);
    tick(2);

    // Reset after five bytes, then a fresh load from address 0.
    new_prog();
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    pulse_start();
    begin
      int n = 0;
      while (wr_count < 5 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rst5_writes",      wr_count, 32'd5);
    tick(3);
    chk("rst5_loading",     {31'd0, loading}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk_all_zero("midrst");
    rst_n = 1'b1;
    tick(1);
    new_prog();
    push_word(32'h0000_000B);
    push_csum();
    pulse_start();
    wait_end("restart", 200);
    chk("restart_boot_done", {31'd0, boot_done}, 32'd1);
    chk("restart_instr_cnt", {25'd0, instr_count}, 32'd1);
    chk("restart_mem0",      {24'd0, mem[0]}, 32'h0B);
    chk("restart_sb_empty",  exp_q.size(), 32'd0);

    // Gappy RX stream, and a stray load_start in the middle of the load.
    gap_mode = 1'b1;
    new_prog();
    push_word(32'h1234_5613);
    push_word(32'h0010_0093);
    push_word(32'h3020_100B);
    push_csum();
    pulse_start();
    tick(20);
    chk("gap_mid_loading",  {31'd0, loading}, 32'd1);
    pulse_start();
    wait_end("gap", 800);
    gap_mode = 1'b0;
    chk("gap_boot_done",    {31'd0, boot_done}, 32'd1);
    chk("gap_instr_cnt",    {25'd0, instr_count}, 32'd3);
    chk("gap_writes",       wr_count, 32'd12);
    chk("gap_rx_pops",      rx_pops, 12 + CSUM_BYTES);
    chk("gap_mem11",        {24'd0, mem[11]}, 32'h30);
    chk("gap_asm",          asm_instr, 32'h3020_100B);
    chk("gap_sb_empty",     exp_q.size(), 32'd0);
    tick(10);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Terminator word 0x1300000B: XOR of its bytes is 0x18.
    new_prog();
    push_word(32'h1300_000B);
    rx_q.push_back(8'h18);
    pulse_start();
    wait_end("csum_ok", 200);
    chk("csum_ok_done",     {31'd0, boot_done},  32'd1);
    chk("csum_ok_error",    {31'd0, load_error}, 32'd0);
    chk("csum_ok_writes",   wr_count, 32'd4);
    chk("csum_ok_pops",     rx_pops,  32'd5);
    new_prog();
    push_word(32'h1300_000B);
    rx_q.push_back(8'h19);
    pulse_start();
    wait_end("csum_bad", 200);
    chk("csum_bad_error",   {31'd0, load_error}, 32'd1);
    chk("csum_bad_done",    {31'd0, boot_done},  32'd0);
    chk("csum_bad_writes",  wr_count, 32'd4);
    chk("csum_bad_cnt",     {25'd0, instr_count}, 32'd1);
    tick(2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
